// File: rtl/split_prefetcher_mq_if.sv
// DRAM request/response channel between the reference prefetcher and the memory side.
//   req_valid/req_ready : request handshake (prefetcher -> DRAM)
//   req_addr/req_len    : byte address and byte length of the request
//   rsp_done            : 1-cycle pulse, one outstanding request completed (DRAM -> prefetcher)
interface split_prefetcher_mq_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_len;
  logic              rsp_done;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready, rsp_done
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready, rsp_done
  );
endinterface

// File: rtl/split_prefetcher_mq.sv
// Reference-frame prefetcher. Each queued group is turned into a halo-extended window clamped to
// the frame, then fetched for N_CH planes, row by row, in bursts of at most MAX_BURST bytes.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset (release synchronised)
//   frame_width_i/frame_height_i  : frame size in pixels/rows, sampled in CALC
//   ref_base_addr_i/plane_stride_i: plane 0 origin and plane spacing, sampled in CALC
//   group_done_i, group_x_i/_y_i  : enqueue one group
//   dram                          : request/response channel (master side)
//   prefetch_done_o               : 1-cycle pulse when a group is fully issued and completed
//   busy_o, outstanding_o         : activity and in-flight request count
//   overflow_err_o                : sticky, a group was dropped because the queue was full
module split_prefetcher_mq #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned TILE_SIZE       = 16,
  parameter int unsigned GROUP_ROWS      = 4,
  parameter int unsigned HALO            = 1,
  parameter int unsigned N_CH            = 2,
  parameter int unsigned PIX_BYTES       = 2,
  parameter int unsigned MAX_BURST       = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned GQ_DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_width_i,
  input  logic [15:0]           frame_height_i,
  input  logic [ADDR_W-1:0]     ref_base_addr_i,
  input  logic [ADDR_W-1:0]     plane_stride_i,
  input  logic                  group_done_i,
  input  logic [15:0]           group_x_i,
  input  logic [15:0]           group_y_i,
  split_prefetcher_mq_if.master dram,
  output logic                  prefetch_done_o,
  output logic                  busy_o,
  output logic [2:0]            outstanding_o,
  output logic                  overflow_err_o
);
  localparam int unsigned PtrW = (GQ_DEPTH > 1) ? $clog2(GQ_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(GQ_DEPTH + 1);
  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic signed [17:0] GrS = 18'(GROUP_ROWS);
  localparam logic signed [17:0] TsS = 18'(TILE_SIZE);
  localparam logic signed [17:0] HaS = 18'(HALO);
  localparam logic [31:0]        MbW = 32'(MAX_BURST);
  localparam logic [2:0]         MaxOut = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDrain} state_e;

  // Reset: asserts asynchronously, releases two clock edges later.
  logic rst_meta_q, rst_sync_q, rst_int;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_int = rst_sync_q;

  state_e            st_q, st_d;
  logic [15:0]       grp_x_q, grp_x_d, grp_y_q, grp_y_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [15:0]       row_q, row_d, r0_q, r0_d, r1_q, r1_d;
  logic [31:0]       rem_q, rem_d, row_bytes_q, row_bytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d, row_addr_q, row_addr_d, ch_addr_q, ch_addr_d;
  logic [ADDR_W-1:0] pitch_q, pitch_d, stride_q, stride_d;
  logic [2:0]        out_q, out_d;
  logic              ovf_q;

  // Pending-group queue
  logic [15:0]     gq_x_q [GQ_DEPTH];
  logic [15:0]     gq_y_q [GQ_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] gq_cnt_q;
  logic            gq_empty, gq_full, gq_pop, gq_push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(GQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign gq_empty = (gq_cnt_q == '0);
  assign gq_full  = (gq_cnt_q == CntW'(GQ_DEPTH));
  assign gq_pop   = (st_q == StIdle) && !gq_empty;
  // A pop in the same cycle frees a slot, so the push is still honoured.
  assign gq_push  = group_done_i && (!gq_full || gq_pop);

  always_ff @(posedge clk) begin
    if (gq_push) begin
      gq_x_q[wr_ptr_q] <= group_x_i;
      gq_y_q[wr_ptr_q] <= group_y_i;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      gq_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (gq_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (gq_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (gq_push && !gq_pop)      gq_cnt_q <= gq_cnt_q + 1'b1;
      else if (!gq_push && gq_pop) gq_cnt_q <= gq_cnt_q - 1'b1;
      if (group_done_i && !gq_push) ovf_q <= 1'b1;
    end
  end

  // Window bounds, signed 18-bit so that the halo may go negative before clamping.
  logic signed [17:0] gx_s, gy_s, r0_raw, r1_raw, c0_raw, c1_raw, h_last, w_last;
  logic signed [17:0] r0_c, r1_c, c0_c, c1_c;
  logic               win_empty;
  logic [31:0]        row_bytes_calc;
  logic [ADDR_W-1:0]  win_addr, pitch_calc;

  assign gx_s   = $signed({2'b00, grp_x_q});
  assign gy_s   = $signed({2'b00, grp_y_q});
  assign h_last = $signed({2'b00, frame_height_i}) - 18'sd1;
  assign w_last = $signed({2'b00, frame_width_i}) - 18'sd1;
  assign r0_raw = gy_s * GrS - HaS;
  assign r1_raw = gy_s * GrS + GrS - 18'sd1 + HaS;
  assign c0_raw = gx_s * TsS - HaS;
  assign c1_raw = gx_s * TsS + TsS - 18'sd1 + HaS;
  assign r0_c   = (r0_raw < 18'sd0) ? 18'sd0 : r0_raw;
  assign r1_c   = (r1_raw > h_last) ? h_last : r1_raw;
  assign c0_c   = (c0_raw < 18'sd0) ? 18'sd0 : c0_raw;
  assign c1_c   = (c1_raw > w_last) ? w_last : c1_raw;
  assign win_empty = (r0_c > r1_c) || (c0_c > c1_c);

  assign row_bytes_calc = (32'(c1_c) - 32'(c0_c) + 32'd1) * 32'(PIX_BYTES);
  assign pitch_calc     = ADDR_W'(32'(frame_width_i) * 32'(PIX_BYTES));
  assign win_addr       = ref_base_addr_i +
      ADDR_W'((32'(r0_c) * 32'(frame_width_i) + 32'(c0_c)) * 32'(PIX_BYTES));

  // Request channel: registers only advance on accept, so addr/len hold while stalled.
  logic req_valid, accept;
  assign req_valid      = (st_q == StIssue) && (out_q < MaxOut);
  assign accept         = req_valid && dram.req_ready;
  assign dram.req_valid = req_valid;
  assign dram.req_addr  = addr_q;
  assign dram.req_len   = (rem_q > MbW) ? 16'(MAX_BURST) : rem_q[15:0];

  always_comb begin
    out_d = out_q;
    if (accept && !(dram.rsp_done && out_q != 3'd0)) out_d = out_q + 3'd1;
    else if (!accept && dram.rsp_done && out_q != 3'd0) out_d = out_q - 3'd1;
  end

  always_comb begin
    st_d        = st_q;
    grp_x_d     = grp_x_q;
    grp_y_d     = grp_y_q;
    ch_d        = ch_q;
    row_d       = row_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    rem_d       = rem_q;
    row_bytes_d = row_bytes_q;
    addr_d      = addr_q;
    row_addr_d  = row_addr_q;
    ch_addr_d   = ch_addr_q;
    pitch_d     = pitch_q;
    stride_d    = stride_q;
    unique case (st_q)
      StIdle: begin
        if (!gq_empty) begin
          grp_x_d = gq_x_q[rd_ptr_q];
          grp_y_d = gq_y_q[rd_ptr_q];
          st_d    = StCalc;
        end
      end
      StCalc: begin
        if (win_empty) begin
          st_d = StDrain;
        end else begin
          ch_d        = '0;
          row_d       = 16'(r0_c);
          r0_d        = 16'(r0_c);
          r1_d        = 16'(r1_c);
          rem_d       = row_bytes_calc;
          row_bytes_d = row_bytes_calc;
          addr_d      = win_addr;
          row_addr_d  = win_addr;
          ch_addr_d   = win_addr;
          pitch_d     = pitch_calc;
          stride_d    = plane_stride_i;
          st_d        = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          if (rem_q > MbW) begin
            rem_d  = rem_q - MbW;
            addr_d = addr_q + ADDR_W'(MAX_BURST);
          end else if (row_q != r1_q) begin
            row_d      = row_q + 16'd1;
            row_addr_d = row_addr_q + pitch_q;
            addr_d     = row_addr_q + pitch_q;
            rem_d      = row_bytes_q;
          end else if (ch_q != ChW'(N_CH - 1)) begin
            ch_d       = ch_q + 1'b1;
            ch_addr_d  = ch_addr_q + stride_q;
            row_addr_d = ch_addr_q + stride_q;
            addr_d     = ch_addr_q + stride_q;
            row_d      = r0_q;
            rem_d      = row_bytes_q;
          end else begin
            st_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_q == 3'd0) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      st_q        <= StIdle;
      grp_x_q     <= '0;
      grp_y_q     <= '0;
      ch_q        <= '0;
      row_q       <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      rem_q       <= '0;
      row_bytes_q <= '0;
      addr_q      <= '0;
      row_addr_q  <= '0;
      ch_addr_q   <= '0;
      pitch_q     <= '0;
      stride_q    <= '0;
      out_q       <= '0;
    end else begin
      st_q        <= st_d;
      grp_x_q     <= grp_x_d;
      grp_y_q     <= grp_y_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      rem_q       <= rem_d;
      row_bytes_q <= row_bytes_d;
      addr_q      <= addr_d;
      row_addr_q  <= row_addr_d;
      ch_addr_q   <= ch_addr_d;
      pitch_q     <= pitch_d;
      stride_q    <= stride_d;
      out_q       <= out_d;
    end
  end

  assign prefetch_done_o = (st_q == StDrain) && (out_q == 3'd0);
  assign busy_o          = !gq_empty || (st_q != StIdle) || (out_q != 3'd0);
  assign outstanding_o   = out_q;
  assign overflow_err_o  = ovf_q;

endmodule

// File: tb/tb_split_prefetcher_mq.sv
// Scoreboard bench for split_prefetcher_mq: directed groups push hand-derived request lists,
// a negedge monitor pops and compares every accepted request.
module tb_split_prefetcher_mq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] fw, fh, gx, gy;
  logic [31:0] base, stride;
  logic        gdone;
  logic        pdone, busy, ovf;
  logic [2:0]  outst;

  always #5 clk = ~clk;

  split_prefetcher_mq_if #(.ADDR_W(32)) bus ();

  split_prefetcher_mq dut (
    .clk             (clk),
    .rst             (rst),
    .frame_width_i   (fw),
    .frame_height_i  (fh),
    .ref_base_addr_i (base),
    .plane_stride_i  (stride),
    .group_done_i    (gdone),
    .group_x_i       (gx),
    .group_y_i       (gy),
    .dram            (bus),
    .prefetch_done_o (pdone),
    .busy_o          (busy),
    .outstanding_o   (outst),
    .overflow_err_o  (ovf)
  );

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic [47:0] exp_q[$];
  logic        auto_rsp = 1'b1;
  logic        man_rsp = 1'b0;
  logic [2:0]  rsp_pipe = 3'b000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DRAM model: completes each accepted request two cycles later, or follows man_rsp.
  always @(negedge clk) begin
    if (rst) rsp_pipe = 3'b000;
    else rsp_pipe = {rsp_pipe[1:0], bus.req_valid && bus.req_ready};
    bus.rsp_done = auto_rsp ? rsp_pipe[2] : man_rsp;
  end

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected no request",
                   bus.req_addr, bus.req_len);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", 64'(bus.req_addr), 64'(e[47:16]));
          chk("req_len", 64'(bus.req_len), 64'(e[15:0]));
        end
      end
      if (pdone) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expand a hand-derived window (first address, rows, bytes per row) into 2-plane bursts.
  task automatic exp_group(input logic [31:0] first, input int rows, input int row_bytes);
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < rows; r++) begin
        int          rem = row_bytes;
        logic [31:0] a = first + 32'(ch) * 32'h1000 + 32'(r) * 32'd128;
        while (rem > 0) begin
          int len = (rem > 32) ? 32 : rem;
          exp_q.push_back({a, 16'(len)});
          a   = a + 32'(len);
          rem = rem - len;
        end
      end
    end
  endtask

  task automatic pulse_group(input logic [15:0] x, input logic [15:0] y);
    gx    = x;
    gy    = y;
    gdone = 1'b1;
    cyc(1);
    gdone = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(done_cnt), 64'(target));
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          h0, d0, first, n;
    logic [31:0] ha;
    logic [15:0] hl;
    gdone = 1'b0;
    gx = '0;
    gy = '0;
    fw = 16'd64;
    fh = 16'd32;
    base = 32'h1000;
    stride = 32'h1000;
    bus.req_ready = 1'b0;
    #2 rst = 1'b1;
    cyc(3);
    chk("rst_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_pdone", 64'(pdone), 64'd0);
    rst = 1'b0;
    cyc(5);
    chk("idle_busy", 64'(busy), 64'd0);

    // 1: group (0,0): rows 0..4, cols 0..16 -> 34 B per row -> 32+2
    bus.req_ready = 1'b1;
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h1000, 5, 34);
    gx = 16'd0;
    gy = 16'd0;
    gdone = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_valid && first < 0) first = k;
      @(posedge clk);
      #1 gdone = 1'b0;
    end
    chk("t1_latency", 64'(first), 64'd3);
    wait_done(d0 + 1, 300, "t1_done");
    chk("t1_reqs", 64'(hs_cnt - h0), 64'd20);

    // 2: group (3,7): rows 27..31, cols 47..63, first (27*64+47)*2 = 0xDDE past base
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h1DDE, 5, 34);
    pulse_group(16'd3, 16'd7);
    wait_done(d0 + 1, 300, "t2_done");
    chk("t2_reqs", 64'(hs_cnt - h0), 64'd20);

    // 3: group (1,0): cols 15..32 -> 36 B -> 32+4; stall ready mid-stream
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h101E, 5, 36);
    pulse_group(16'd1, 16'd0);
    n = 0;
    while (hs_cnt - h0 < 5 && n < 50) begin
      cyc(1);
      n++;
    end
    bus.req_ready = 1'b0;
    @(negedge clk);
    ha = bus.req_addr;
    hl = bus.req_len;
    chk("t3_stall_valid", 64'(bus.req_valid), 64'd1);
    chk("t3_held_addr_model", 64'(ha), 64'(exp_q[0][47:16]));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(bus.req_valid), 64'd1);
      chk("t3_hold_addr", 64'(bus.req_addr), 64'(ha));
      chk("t3_hold_len", 64'(bus.req_len), 64'(hl));
    end
    @(posedge clk);
    #1 bus.req_ready = 1'b1;
    wait_done(d0 + 1, 300, "t3_done");
    chk("t3_reqs", 64'(hs_cnt - h0), 64'd20);

    // 4: outstanding limit and simultaneous accept/complete
    auto_rsp = 1'b0;
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h1000, 5, 34);
    pulse_group(16'd0, 16'd0);
    cyc(15);
    chk("t4_cap_reqs", 64'(hs_cnt - h0), 64'd4);
    chk("t4_cap_valid", 64'(bus.req_valid), 64'd0);
    chk("t4_cap_outst", 64'(outst), 64'd4);
    man_rsp = 1'b1;
    cyc(1);
    man_rsp = 1'b0;
    cyc(6);
    chk("t4_one_more", 64'(hs_cnt - h0), 64'd5);
    chk("t4_outst_a", 64'(outst), 64'd4);
    man_rsp = 1'b1;
    cyc(2);
    man_rsp = 1'b0;
    cyc(6);
    chk("t4_coincident_reqs", 64'(hs_cnt - h0), 64'd7);
    chk("t4_outst_b", 64'(outst), 64'd4);
    man_rsp = 1'b1;
    wait_done(d0 + 1, 300, "t4_done");
    man_rsp = 1'b0;
    cyc(4);
    auto_rsp = 1'b1;
    cyc(4);
    chk("t4_outst_end", 64'(outst), 64'd0);

    // 5: three pulses while busy; the third is dropped
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h1000, 5, 34);
    exp_group(32'h101E, 5, 36);
    exp_group(32'h1DDE, 5, 34);
    pulse_group(16'd0, 16'd0);
    cyc(4);
    gx = 16'd1;
    gy = 16'd0;
    gdone = 1'b1;
    cyc(1);
    gx = 16'd3;
    gy = 16'd7;
    cyc(1);
    gx = 16'd2;
    gy = 16'd0;
    cyc(1);
    gdone = 1'b0;
    chk("t5_overflow", 64'(ovf), 64'd1);
    wait_done(d0 + 3, 600, "t5_done");
    chk("t5_reqs", 64'(hs_cnt - h0), 64'd60);

    // 6a: off-frame group -> no requests, done in the cycle after CALC
    h0 = hs_cnt;
    d0 = done_cnt;
    gx = 16'd10;
    gy = 16'd0;
    gdone = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pdone && first < 0) first = k;
      @(posedge clk);
      #1 gdone = 1'b0;
    end
    chk("t6_done_cycle", 64'(first), 64'd3);
    chk("t6_no_reqs", 64'(hs_cnt - h0), 64'd0);
    chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 6b: reset during ISSUE, then a clean restart
    h0 = hs_cnt;
    exp_group(32'h1000, 5, 34);
    pulse_group(16'd0, 16'd0);
    n = 0;
    while (hs_cnt - h0 < 3 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("t6_in_issue", 64'(hs_cnt - h0 >= 3), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.req_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_outst", 64'(outst), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    chk("t6_rst_pdone", 64'(pdone), 64'd0);
    exp_q.delete();
    cyc(3);
    rst = 1'b0;
    cyc(5);
    h0 = hs_cnt;
    d0 = done_cnt;
    exp_group(32'h1DDE, 5, 34);
    pulse_group(16'd3, 16'd7);
    wait_done(d0 + 1, 300, "t6_restart_done");
    chk("t6_restart_reqs", 64'(hs_cnt - h0), 64'd20);
    chk("t6_restart_ovf", 64'(ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
